// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver with selectable baud divider and a write-FIFO port.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit centre.
module uart_byte_rx #(
  parameter int DATA_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] baud_set,
  input  logic       rs232_rx,
  output logic [7:0] data_byte,
  output logic       rx_done,
  output logic       uart_state,
  output logic       frame_err,
  input  logic       wfifo_full,
  output logic       wfifo_wr_en,
  output logic [7:0] wfifo_wr_data,
  output logic       overrun
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  function automatic logic [12:0] baud_dr(input logic [3:0] sel);
    case (sel)
      4'd0:    baud_dr = 13'd31;
      4'd1:    baud_dr = 13'd2603;
      4'd2:    baud_dr = 13'd1302;
      4'd3:    baud_dr = 13'd867;
      4'd4:    baud_dr = 13'd432;
      default: baud_dr = 13'd5207;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [12:0] div_cnt_q, div_cnt_d;
  logic [12:0] dr_q, dr_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_s3_q, rx_s3_d;
  logic [1:0]  sync_vld_q, sync_vld_d;
  logic        armed_q, armed_d;
  logic        start_pend_q, start_pend_d;
  logic        uart_state_q, uart_state_d;
  logic [7:0]  data_byte_q, data_byte_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        rx_done_q, rx_done_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
  logic        wr_en_q, wr_en_d;

  logic [12:0] mid_s;
  logic        samp_at_s, samp_bit_s, wrap_s, fall_s;

  assign mid_s  = {1'b0, dr_q[12:1]};
  assign wrap_s = (div_cnt_q == dr_q);
  assign fall_s = rx_s3_q & ~rx_s2_q;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] maj_q, maj_d;

  assign samp_at_s  = (div_cnt_q == mid_s + 13'd1);
  assign samp_bit_s = (maj_q[0] & maj_q[1]) | (maj_q[0] & rx_s2_q) | (maj_q[1] & rx_s2_q);

  // Capture the two early votes of the majority window
  always_comb begin
    maj_d = maj_q;
    if (div_cnt_q == mid_s - 13'd1) begin
      maj_d[0] = rx_s2_q;
    end else if (div_cnt_q == mid_s) begin
      maj_d[1] = rx_s2_q;
    end else begin
      maj_d = maj_q;
    end
  end

  // Majority vote registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      maj_q <= 2'b11;
    end else begin
      maj_q <= maj_d;
    end
  end
`else
  assign samp_at_s  = (div_cnt_q == mid_s);
  assign samp_bit_s = rx_s2_q;
`endif

  // Next-state logic for synchroniser, frame FSM and registered outputs
  always_comb begin
    rx_s1_d      = rs232_rx;
    rx_s2_d      = rx_s1_q;
    rx_s3_d      = rx_s2_q;
    // The line only counts as idle-high once real samples have reached the synchroniser output
    sync_vld_d   = {sync_vld_q[0], 1'b1};
    armed_d      = armed_q | (sync_vld_q[1] & rx_s2_q);
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    dr_d         = dr_q;
    shift_d      = shift_q;
    start_pend_d = start_pend_q;
    uart_state_d = uart_state_q;
    data_byte_d  = data_byte_q;
    wr_data_d    = wr_data_q;
    rx_done_d    = 1'b0;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    wr_en_d      = 1'b0;

    if ((state_q == IDLE) || wrap_s) begin
      div_cnt_d = 13'd0;
    end else begin
      div_cnt_d = div_cnt_q + 13'd1;
    end

    case (state_q)
      IDLE: begin
        if (armed_q && (fall_s || start_pend_q)) begin
          state_d      = START;
          dr_d         = baud_dr(baud_set);
          uart_state_d = 1'b1;
          start_pend_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (samp_at_s && samp_bit_s) begin
          state_d      = IDLE;
          uart_state_d = 1'b0;
        end else if (wrap_s) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (samp_at_s) begin
          shift_d = {samp_bit_s, shift_q[7:1]};
        end else begin
          shift_d = shift_q;
        end
        if (wrap_s && (bit_cnt_q == LAST_BIT)) begin
          state_d = STOP;
        end else if (wrap_s) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
        end else begin
          state_d = DATA;
        end
      end
      STOP: begin
        // Leave half a bit early so a back-to-back start edge is not missed
        if (samp_at_s) begin
          state_d      = IDLE;
          uart_state_d = 1'b0;
          bit_cnt_d    = 3'd0;
          start_pend_d = fall_s;
          if (samp_bit_s) begin
            rx_done_d   = 1'b1;
            data_byte_d = shift_q;
            if (!wfifo_full) begin
              wr_en_d   = 1'b1;
              wr_data_d = shift_q;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d      = IDLE;
        uart_state_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      div_cnt_q    <= 13'd0;
      dr_q         <= 13'd0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'd0;
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_s3_q      <= 1'b1;
      sync_vld_q   <= 2'b00;
      armed_q      <= 1'b0;
      start_pend_q <= 1'b0;
      uart_state_q <= 1'b0;
      data_byte_q  <= 8'd0;
      wr_data_q    <= 8'd0;
      rx_done_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      wr_en_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      dr_q         <= dr_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rx_s1_q      <= rx_s1_d;
      rx_s2_q      <= rx_s2_d;
      rx_s3_q      <= rx_s3_d;
      sync_vld_q   <= sync_vld_d;
      armed_q      <= armed_d;
      start_pend_q <= start_pend_d;
      uart_state_q <= uart_state_d;
      data_byte_q  <= data_byte_d;
      wr_data_q    <= wr_data_d;
      rx_done_q    <= rx_done_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      wr_en_q      <= wr_en_d;
    end
  end

  assign data_byte     = data_byte_q;
  assign rx_done       = rx_done_q;
  assign uart_state    = uart_state_q;
  assign frame_err     = frame_err_q;
  assign wfifo_wr_en   = wr_en_q;
  assign wfifo_wr_data = wr_data_q;
  assign overrun       = overrun_q;

endmodule
